// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared state/rule encodings and hazard priority helper for hazard_ctrl
// Statistics counters are built only with HAZARD_STATS_EN; STAT_W_DEF is their default width.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALT   = 2'd1,
    ST_RESUME = 2'd2
  } state_t;

  // Per-cycle control rule actually applied to the pipeline
  typedef enum logic [2:0] {
    R_NONE   = 3'd0,
    R_HOLD   = 3'd1,
    R_BRANCH = 3'd2,
    R_STALL  = 3'd3,
    R_JUMP   = 3'd4
  } rule_t;

  localparam int STAT_W_DEF = 32;

  // A taken branch makes the ID instruction wrong-path, so it outranks load-use
  function automatic rule_t pick_hazard(input logic branch_taken,
                                        input logic load_use,
                                        input logic jump_id);
    if (branch_taken)  return R_BRANCH;
    else if (load_use) return R_STALL;
    else if (jump_id)  return R_JUMP;
    else               return R_NONE;
  endfunction

endpackage

// File: rtl/hazard_ctrl_go_edge_detect.sv
// rtl/hazard_ctrl_go_edge_detect.sv - registered copy of go and its rising-edge pulse
module go_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic go,
  output logic rise
);

  logic go_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) go_q <= 1'b0;
    else     go_q <= go;
  end

  assign rise = go & ~go_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline sequencing controller: syscall halt/resume plus hazard priority decode
// Optional load-use/flush statistics counters enabled by HAZARD_STATS_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              syscall_ex,
  input  logic              show,
  input  logic              go,
  input  logic              load_use,
  input  logic              branch_taken,
  input  logic              jump_id,
  output logic              pc_enable,
  output logic              ifid_enable,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              halted,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] flush_cnt
);

  state_t state, next_state;
  rule_t  rule;
  rule_t  hazard_rule;
  logic   go_rise;

  go_edge_detect u_go_edge (
    .clk  (clk),
    .rst  (rst),
    .go   (go),
    .rise (go_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= next_state;
  end

  assign hazard_rule = pick_hazard(branch_taken, load_use, jump_id);

  // RESUME ignores syscall_ex so the halting syscall can drain out of EX
  always_comb begin
    next_state = state;
    rule       = R_NONE;
    case (state)
      ST_RUN: begin
        if (syscall_ex && !show) begin
          rule       = R_HOLD;
          next_state = ST_HALT;
        end else begin
          rule = hazard_rule;
        end
      end
      ST_HALT: begin
        rule = R_HOLD;
        if (go_rise) next_state = ST_RESUME;
      end
      ST_RESUME: begin
        rule       = hazard_rule;
        next_state = ST_RUN;
      end
      default: begin
        rule       = R_HOLD;
        next_state = ST_RUN;
      end
    endcase
  end

  always_comb begin
    pc_enable   = 1'b1;
    ifid_enable = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    case (rule)
      R_HOLD: begin
        pc_enable   = 1'b0;
        ifid_enable = 1'b0;
      end
      R_BRANCH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      R_STALL: begin
        pc_enable   = 1'b0;
        ifid_enable = 1'b0;
        idex_flush  = 1'b1;
      end
      R_JUMP: begin
        ifid_flush = 1'b1;
      end
      default: ;
    endcase
  end

  assign halted = (state == ST_HALT);

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_q;
  logic [STAT_W-1:0] flush_q;

  // HOLD is never counted, so both counters stay frozen while halted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (rule == R_STALL)
        stall_q <= stall_q + STAT_W'(1);
      if (rule == R_BRANCH || rule == R_JUMP)
        flush_q <= flush_q + STAT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl (STAT_W=4; counter checks follow HAZARD_STATS_EN)
module tb_hazard_ctrl;

  localparam int W = 4;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int M_RUN = 0, M_HALT = 1, M_RESUME = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic syscall_ex = 0, show = 0, go = 0, load_use = 0, branch_taken = 0, jump_id = 0;
  logic pc_enable, ifid_enable, ifid_flush, idex_flush, halted;
  logic [W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.STAT_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .syscall_ex   (syscall_ex),
    .show         (show),
    .go           (go),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .jump_id      (jump_id),
    .pc_enable    (pc_enable),
    .ifid_enable  (ifid_enable),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .halted       (halted),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] ctrl;
    logic [4:0] mask;
  } ctrl_exp_t;

  typedef struct {
    logic [W-1:0] stall;
    logic [W-1:0] flush;
  } cnt_exp_t;

  ctrl_exp_t ctrl_q[$];
  cnt_exp_t  cnt_q[$];

  int errors = 0;
  int checks = 0;

  int           m_state = M_RUN;
  logic         m_go_q  = 1'b0;
  logic [W-1:0] m_stall = '0;
  logic [W-1:0] m_flush = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] dut_ctrl();
    return {pc_enable, ifid_enable, ifid_flush, idex_flush, halted};
  endfunction

  task automatic model_reset();
    m_state = M_RUN;
    m_go_q  = 1'b0;
    m_stall = '0;
    m_flush = '0;
    ctrl_q.delete();
    cnt_q.delete();
  endtask

  // One clock cycle: drive at negedge, check controls, then counters after the edge
  task automatic cycle(input logic s, input logic sh, input logic g,
                       input logic lu, input logic br, input logic j);
    int        rule;
    int        nxt;
    ctrl_exp_t ce;
    cnt_exp_t  ke;
    ctrl_exp_t cg;
    cnt_exp_t  kg;
    @(negedge clk);
    syscall_ex = s; show = sh; go = g; load_use = lu; branch_taken = br; jump_id = j;
    if (m_state == M_HALT) begin
      rule = 1;
      nxt  = (g && !m_go_q) ? M_RESUME : M_HALT;
    end else if (m_state == M_RUN && s && !sh) begin
      rule = 1;
      nxt  = M_HALT;
    end else begin
      rule = br ? 2 : lu ? 3 : j ? 4 : 0;
      nxt  = M_RUN;
    end
    case (rule)
      1:       begin ce.ctrl = {4'b0000, (m_state == M_HALT)}; ce.mask = 5'b11111; end
      2:       begin ce.ctrl = 5'b10110; ce.mask = 5'b10111; end
      3:       begin ce.ctrl = 5'b00010; ce.mask = 5'b11111; end
      4:       begin ce.ctrl = 5'b11100; ce.mask = 5'b11111; end
      default: begin ce.ctrl = 5'b11000; ce.mask = 5'b11111; end
    endcase
    if (STATS) begin
      if (rule == 3) m_stall = m_stall + 1'b1;
      if (rule == 2 || rule == 4) m_flush = m_flush + 1'b1;
    end
    ke.stall = m_stall;
    ke.flush = m_flush;
    ctrl_q.push_back(ce);
    cnt_q.push_back(ke);
    m_state = nxt;
    m_go_q  = g;
    #1;
    cg = ctrl_q.pop_front();
    check("ctrl", 32'(dut_ctrl() & cg.mask), 32'(cg.ctrl & cg.mask));
    @(posedge clk);
    #1;
    kg = cnt_q.pop_front();
    check("stall_cnt", 32'(stall_cnt), 32'(kg.stall));
    check("flush_cnt", 32'(flush_cnt), 32'(kg.flush));
  endtask

  initial begin
    #2;
    check("rst_ctrl", 32'(dut_ctrl()), 32'(5'b11000));
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_flush", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    cycle(0, 0, 0, 0, 0, 0);
    // display syscall never halts
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    // three load-use stalls
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0);
    check("stall_3", 32'(stall_cnt), STATS ? 32'd3 : 32'd0);
    // branch beats load-use
    cycle(0, 0, 0, 1, 1, 0);
    check("stall_kept", 32'(stall_cnt), STATS ? 32'd3 : 32'd0);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 1);

    // halt with go already high: no resume until a fresh 0->1
    cycle(0, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 1, 1, 1);
    check("halted_rise", 32'(halted), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 1, 0, 1);
    cycle(1, 0, 0, 0, 1, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 1, 0, 0);
    check("resume_no_rehalt", 32'(halted), 32'd0);
    cycle(0, 0, 1, 0, 0, 0);

    // halt again and reset mid-HALT
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("halted_pre_rst", 32'(halted), 32'd1);
    @(negedge clk);
    syscall_ex = 0; show = 0; go = 0; load_use = 0; branch_taken = 0; jump_id = 0;
    rst = 1'b1;
    #1;
    check("midhalt_rst_ctrl", 32'(dut_ctrl()), 32'(5'b11000));
    check("midhalt_rst_stall", 32'(stall_cnt), 32'd0);
    check("midhalt_rst_flush", 32'(flush_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 17 jumps wrap a 4-bit flush counter to 1
    for (int i = 0; i < 17; i++) cycle(0, 0, 0, 0, 0, 1);
    check("flush_wrap", 32'(flush_cnt), STATS ? 32'd1 : 32'd0);

    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 7) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage MIPS core: the single owner of the PC enable, IF/ID register enable and the IF/ID and ID/EX flush controls. It resolves syscall halt/resume, load-use stalls, taken branches and jumps into one consistent per-cycle control set. It sits between the hazard detection logic, the EX-stage branch resolution and the PC/pipeline registers, and replaces the ad-hoc PC-enable flop.

## Interface
Parameters:
- STAT_W, 32, width of the statistics counters (only used with HAZARD_STATS_EN)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- syscall_ex  input  1  syscall instruction currently in EX stage
- show  input  1  syscall is a display call (no halt) when 1
- go  input  1  resume request from board button, level, synchronised upstream
- load_use  input  1  ID instruction reads the destination of a load in EX
- branch_taken  input  1  conditional branch in EX resolved taken
- jump_id  input  1  J/JAL/JR decoded in ID
- pc_enable  output  1  PC register load enable
- ifid_enable  output  1  IF/ID register load enable
- ifid_flush  output  1  IF/ID register clear (wins over ifid_enable)
- idex_flush  output  1  ID/EX register clear (bubble insert)
- halted  output  1  controller in HALT state
- stall_cnt  output  STAT_W  load-use stall cycles (HAZARD_STATS_EN only)
- flush_cnt  output  STAT_W  branch/jump flush events (HAZARD_STATS_EN only)

## Operation
- States: RUN, HALT, RESUME. Encoding in shared package.
- RUN: syscall_ex & ~show -> HALT next edge; this cycle already freezes (pc_enable=0, ifid_enable=0, no flushes).
- HALT: all enables 0, flushes 0, halted=1. Rising edge of go (go=1 while go_q=0, go_q registered) -> RESUME.
- RESUME: one cycle, syscall_ex ignored, normal hazard rules apply -> RUN. Lets the halting syscall leave EX.
- go held high through HALT entry does not resume; a new 0->1 transition is required.
- Hazard rules in RUN/RESUME, priority high to low:
  - branch_taken: pc_enable=1, ifid_flush=1, idex_flush=1 (overrides load_use: ID instruction is wrong-path).
  - load_use: pc_enable=0, ifid_enable=0, idex_flush=1.
  - jump_id: pc_enable=1, ifid_enable=1, ifid_flush=1, idex_flush=0.
  - none: pc_enable=1, ifid_enable=1, flushes 0.
- Halt condition beats every hazard rule.
- Reset (any time, including mid-HALT): state RUN, go_q 0, counters 0; outputs then pc_enable=1, ifid_enable=1, flushes 0, halted=0 with all inputs low.

## Timing
- Control outputs combinational from state and current inputs: zero-cycle latency.
- State, go_q and counters registered on posedge clk; async clear on rst.
- HALT entry: halted rises one edge after syscall_ex & ~show observed.
- Resume: go edge sampled at edge N -> RESUME during cycle N..N+1 -> RUN at N+1.
- Counters increment on the edge ending a cycle in which the event's rule was selected; wrap modulo 2^STAT_W; frozen in HALT.

## Configuration
- HAZARD_STATS_EN defined: stall_cnt counts cycles where the load_use rule was selected; flush_cnt counts cycles where branch_taken or jump_id rule was selected.
- Not defined: counters not built; stall_cnt and flush_cnt tied to 0.

## Structure
- Shared package: state enum (RUN/HALT/RESUME), STAT_W default constant.
- One sub-module: go_edge_detect (go_q flop + rising-edge pulse, async reset).
- Remainder: state register, next-state logic, priority decode for controls, optional counters.

## Test plan
- Reset mid-HALT: rst pulse while halted=1 -> halted=0, pc_enable=1, counters 0 immediately.
- Syscall show=0 -> pc_enable=0 same cycle, halted=1 next edge; go held high from before -> stays halted; go 0->1 -> one RESUME cycle with syscall_ex still 1 and no re-halt, then RUN.
- Syscall with show=1 -> no halt, pc_enable stays 1.
- load_use for 3 cycles -> pc_enable=0, ifid_enable=0, idex_flush=1 each cycle; stall_cnt=3.
- load_use and branch_taken together -> pc_enable=1, ifid_flush=1, idex_flush=1; flush_cnt+1, stall_cnt unchanged.
- jump_id alone -> ifid_flush=1, idex_flush=0; with STAT_W=4, 17 flush events -> flush_cnt=1 (wrap).
